issue_ctrl: RTL
===============

// Module: issue_ctrl
// PURPOSE
//  Dual-issue scheduler for the launch stage. Latches the decoded instruction pair's hazard fields.
//  Tracks outstanding register writes in a 32-entry scoreboard.
//  Each cycle, decides which held instruction(s) go to which execute port; the launch datapath steers payloads from the decisions.
//  Issue is in order: the younger instruction (B) never issues before the older one (A).
// PARAMETERS
//  REG_NUM   32  architectural registers (scoreboard depth); x0 is never busy
//  REG_AW    5   register index width, = clog2(REG_NUM)
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous reset, active-high
//  stop       in   1   pipeline freeze: no accept, no issue, state held
//  flush      in   1   branch redirect: discard held instructions
//  pair_valid in   1   decode presents a pair (A=in1, B=in2)
//  pair_ready out  1   controller accepts the pair this cycle
//  a_vld,b_vld in  1   slot occupancy; B may be invalid (odd fetch)
//  a_rs1,a_rs2,a_rd  in  REG_AW  slot A source/dest regs (B likewise: b_*)
//  a_we,b_we  in   1   instruction writes rd
//  a_cls,b_cls in  2   unit class: 0 ALU, 1 BRANCH, 2 LSU
//  p0_rdy,p1_rdy in 1  execute port ready; port0 = ALU|BRANCH, port1 = ALU|LSU
//  iss0_en,iss1_en out 1  port issues this cycle (combinational)
//  iss0_sel,iss1_sel out 1 slot routed to port: 0=A, 1=B
//  wb_en      in   2   writeback lanes retiring a register
//  wb_rd0,wb_rd1 in REG_AW writeback destinations
//  l_flag     out  4   registered {iss1_sel,iss1_en,iss0_sel,iss0_en} of the previous cycle
// BEHAVIOUR
//  Reset: state=EMPTY, scoreboard=0, held fields=0, l_flag=0; pair_ready=1 once rst drops.
//  States:
//   - EMPTY: nothing held.
//   - PAIR: A held; B held if b_vld.
//   - SOLO: only B left, now treated as oldest.
//  Accept: pair_valid & pair_ready & !stop latches the fields.
//   - Next state is PAIR, or EMPTY if !a_vld & !b_vld.
//   - First issue is possible the cycle after accept.
//  pair_ready = !stop & !flush & (EMPTY | every held instruction issues this cycle).
//   - Back-to-back accept therefore runs at full rate.
//  Oldest (A, or B in SOLO) issues when:
//   - its rs1/rs2 are not busy (x0 ignored), and
//   - a port of its class is ready.
//   - An ALU instruction prefers port0, else port1.
//  B issues in PAIR only if all of the following hold:
//   - A issues the same cycle;
//   - B is not RAW-dependent on A (a_we & a_rd!=0 & a_rd in {b_rs1,b_rs2});
//   - no WAW (a_we & b_we & same rd);
//   - B's sources are not busy;
//   - the other port fits B's class and is ready.
//   - Two BRANCH or two LSU never pair.
//  Transitions:
//   - PAIR -> EMPTY when both issue (or A issues and B invalid).
//   - PAIR -> SOLO when A issues alone.
//   - SOLO -> EMPTY when B issues.
//   - Any -> EMPTY on flush. Flush overrides accept and issue (iss*_en=0 that cycle).
//  Scoreboard:
//   - Set rd on issue when we & rd!=0.
//   - Clear on wb_en[i] for wb_rdi.
//   - Set and clear of the same register in one cycle: set wins.
//   - Two writebacks to the same register: cleared once.
//   - Flush does not touch the scoreboard; older in-flight results still write back.
//  stop=1:
//   - All iss*_en=0 and pair_ready=0.
//   - Scoreboard still clears on writeback.
//   - l_flag updates to 0.
//  Reset asserted mid-pair drops held instructions immediately (asynchronous).
// CONFIGURATION
//  DUAL_ISSUE_EN defined: pairing rules as above.
//  DUAL_ISSUE_EN undefined:
//   - At most one instruction issues per cycle, on port0 or port1 by class.
//   - PAIR always passes through SOLO; iss1_sel/iss0_sel never select B while A is held.
// STRUCTURE
//  def.vh: REG_AW, class codes CLS_ALU/CLS_BR/CLS_LSU, state encodings ST_EMPTY/ST_PAIR/ST_SOLO.
//  Sub-module issue_scoreboard: 32-bit busy vector.
//   - 2 set ports, 2 clear ports, 4 combinational read ports.
//   - Instantiated once.
//  Pairing/port-fit logic and FSM stay in issue_ctrl.
// TESTING
//  1. Independent pair:
//     - Stimulus: A=ALU x1<=x2, B=LSU x3<=x4, ports ready.
//     - Required: iss0_en=iss1_en=1, sel0=A, sel1=B; EMPTY next; l_flag=4'b1101 next cycle.
//  2. RAW in pair:
//     - Stimulus: A writes x5, B reads x5.
//     - Required: A issues alone; SOLO; B waits until wb_rd0=5; issues the cycle wb_en seen +1.
//  3. Class conflict:
//     - Stimulus: A=BRANCH, B=BRANCH.
//     - Required: A on port0 cycle t, B on port0 cycle t+1; never both in one cycle.
//  4. Scoreboard race:
//     - Stimulus: issue writer of x7 while wb_rd1=7 same cycle.
//     - Required: x7 stays busy; a later reader of x7 stalls.
//  5. Flush in SOLO:
//     - Stimulus: held B, flush=1.
//     - Required: iss*_en=0, EMPTY next; scoreboard unchanged; pair_ready=1 the following cycle.
//  6. Single-issue build:
//     - Stimulus: DUAL_ISSUE_EN undefined, rerun test 1.
//     - Required: A cycle t, B cycle t+1; iss1_en and iss0_en never both 1.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the dual-issue launch controller: register index width,
// unit class codes, controller state encodings and the port/class fit helper.
package issue_ctrl_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = $clog2(REG_NUM);

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_BR  = 2'd1;
  localparam logic [1:0] CLS_LSU = 2'd2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PAIR  = 2'd1;
  localparam logic [1:0] ST_SOLO  = 2'd2;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [1:0]        cls;
  } slot_t;

  // port0 executes ALU|BRANCH, port1 executes ALU|LSU
  function automatic logic fits(input logic port, input logic [1:0] cls);
    return port ? (cls == CLS_ALU || cls == CLS_LSU)
                : (cls == CLS_ALU || cls == CLS_BR);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode/issue/writeback signal bundle between the launch stage and issue_ctrl.
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic              stop;
  logic              flush;
  logic              pair_valid;
  logic              pair_ready;
  logic              a_vld, b_vld;
  logic [REG_AW-1:0] a_rs1, a_rs2, a_rd;
  logic [REG_AW-1:0] b_rs1, b_rs2, b_rd;
  logic              a_we, b_we;
  logic [1:0]        a_cls, b_cls;
  logic              p0_rdy, p1_rdy;
  logic              iss0_en, iss1_en;
  logic              iss0_sel, iss1_sel;
  logic [1:0]        wb_en;
  logic [REG_AW-1:0] wb_rd0, wb_rd1;
  logic [3:0]        l_flag;

  modport master (
    output stop, flush, pair_valid, a_vld, b_vld,
           a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd, a_we, b_we, a_cls, b_cls,
           p0_rdy, p1_rdy, wb_en, wb_rd0, wb_rd1,
    input  pair_ready, iss0_en, iss1_en, iss0_sel, iss1_sel, l_flag
  );

  modport slave (
    input  stop, flush, pair_valid, a_vld, b_vld,
           a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd, a_we, b_we, a_cls, b_cls,
           p0_rdy, p1_rdy, wb_en, wb_rd0, wb_rd1,
    output pair_ready, iss0_en, iss1_en, iss0_sel, iss1_sel, l_flag
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Busy vector of outstanding register writes: 2 set ports, 2 clear ports,
// 4 combinational read ports. x0 is never marked busy; set beats clear.
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned NREG = REG_NUM,
  parameter int unsigned AW   = REG_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en0,
  input  logic [AW-1:0]       set_rd0,
  input  logic                set_en1,
  input  logic [AW-1:0]       set_rd1,
  input  logic [1:0]          clr_en,
  input  logic [AW-1:0]       clr_rd0,
  input  logic [AW-1:0]       clr_rd1,
  input  logic [3:0][AW-1:0]  rd_idx,
  output logic [3:0]          rd_busy
);

  logic [NREG-1:0] busy, busy_n, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en0)   set_mask[set_rd0] = 1'b1;
    if (set_en1)   set_mask[set_rd1] = 1'b1;
    if (clr_en[0]) clr_mask[clr_rd0] = 1'b1;
    if (clr_en[1]) clr_mask[clr_rd1] = 1'b1;
    set_mask[0] = 1'b0;
    busy_n = (busy & ~clr_mask) | set_mask;
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < 4; i++) rd_busy[i] = busy[rd_idx[i]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order dual-issue scheduler: holds the decoded pair, checks hazards against the
// scoreboard and routes A/B to the execute ports. Pairing is enabled by DUAL_ISSUE_EN.
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);

  logic [1:0] state, state_n;
  slot_t      a_q, b_q, a_in, b_in;
  logic       b_vld_q;
  logic [3:0] l_flag_q, flags;
  logic [3:0] busy;

  logic              live, in_solo, old_ok, fit0, fit1, old_go, old_port;
  logic [1:0]        old_cls;
  logic [REG_AW-1:0] old_rd;
  logic              old_we, young_go, all_done, pair_ready, accept;
  logic              iss0_en, iss1_en, iss0_sel, iss1_sel;

  assign a_in = '{rs1: bus.a_rs1, rs2: bus.a_rs2, rd: bus.a_rd, we: bus.a_we, cls: bus.a_cls};
  assign b_in = '{rs1: bus.b_rs1, rs2: bus.b_rs2, rd: bus.b_rd, we: bus.b_we, cls: bus.b_cls};

  issue_scoreboard #(.NREG(REG_NUM), .AW(REG_AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en0 (old_go & old_we),
    .set_rd0 (old_rd),
    .set_en1 (young_go & b_q.we),
    .set_rd1 (b_q.rd),
    .clr_en  (bus.wb_en),
    .clr_rd0 (bus.wb_rd0),
    .clr_rd1 (bus.wb_rd1),
    .rd_idx  ({b_q.rs2, b_q.rs1, a_q.rs2, a_q.rs1}),
    .rd_busy (busy)
  );

  // In SOLO the held B becomes the oldest instruction.
  assign in_solo  = (state == ST_SOLO);
  assign old_cls  = in_solo ? b_q.cls : a_q.cls;
  assign old_rd   = in_solo ? b_q.rd  : a_q.rd;
  assign old_we   = in_solo ? b_q.we  : a_q.we;
  assign old_ok   = in_solo ? !(busy[2] | busy[3]) : !(busy[0] | busy[1]);
  assign live     = !bus.stop & !bus.flush;
  assign fit0     = fits(1'b0, old_cls) & bus.p0_rdy;
  assign fit1     = fits(1'b1, old_cls) & bus.p1_rdy;
  assign old_go   = live & (state != ST_EMPTY) & old_ok & (fit0 | fit1);
  assign old_port = !fit0;

`ifdef DUAL_ISSUE_EN
  logic raw, waw, young_fit;
  assign raw       = a_q.we & (a_q.rd != '0) & ((a_q.rd == b_q.rs1) | (a_q.rd == b_q.rs2));
  assign waw       = a_q.we & b_q.we & (a_q.rd == b_q.rd);
  assign young_fit = old_port ? (fits(1'b0, b_q.cls) & bus.p0_rdy)
                              : (fits(1'b1, b_q.cls) & bus.p1_rdy);
  assign young_go  = (state == ST_PAIR) & b_vld_q & old_go & !raw & !waw
                   & !(busy[2] | busy[3]) & young_fit;
`else
  assign young_go  = 1'b0;
`endif

  assign iss0_en  = (old_go & !old_port) | (young_go & old_port);
  assign iss1_en  = (old_go & old_port)  | (young_go & !old_port);
  assign iss0_sel = (old_go & !old_port) ? in_solo : (young_go & old_port);
  assign iss1_sel = (old_go & old_port)  ? in_solo : (young_go & !old_port);
  assign flags    = {iss1_sel, iss1_en, iss0_sel, iss0_en};

  assign all_done   = old_go & (in_solo | !b_vld_q | young_go);
  assign pair_ready = live & ((state == ST_EMPTY) | all_done);
  assign accept     = bus.pair_valid & pair_ready;

  always_comb begin
    state_n = state;
    if (bus.flush)
      state_n = ST_EMPTY;
    else if (accept)
      // A B-only pair starts directly in SOLO since B is already the oldest.
      state_n = bus.a_vld ? ST_PAIR : (bus.b_vld ? ST_SOLO : ST_EMPTY);
    else if (old_go)
      state_n = ((state == ST_PAIR) & b_vld_q & !young_go) ? ST_SOLO : ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      a_q      <= '0;
      b_q      <= '0;
      b_vld_q  <= 1'b0;
      l_flag_q <= '0;
    end else begin
      state    <= state_n;
      l_flag_q <= flags;
      if (accept) begin
        a_q     <= a_in;
        b_q     <= b_in;
        b_vld_q <= bus.b_vld;
      end
    end
  end

  assign bus.pair_ready = pair_ready;
  assign bus.iss0_en    = iss0_en;
  assign bus.iss1_en    = iss1_en;
  assign bus.iss0_sel   = iss0_sel;
  assign bus.iss1_sel   = iss1_sel;
  assign bus.l_flag     = l_flag_q;

endmodule
